// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, the {C,Z,V,N} flag struct and
// the arbiter sequencer state enum.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;

  // Field order gives the packed layout {C,Z,V,N}, MSB first.
  typedef struct packed {
    logic c;
    logic z;
    logic v;
    logic n;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requesting port found scanning
// upward from i_ptr, with wrap-around, wins.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    // Scan from the farthest offset down so the nearest requester is written last.
    for (int off = N - 1; off >= 0; off--) begin
      int k;
      k = int'(i_ptr) + off;
      if (k >= N) k = k - N;
      if (i_req[k]) begin
        o_grant    = '0;
        o_grant[k] = 1'b1;
        o_idx      = IW'(k);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU between NUM_REQ ports.
// Optional sticky overflow flag is built when ALU_ARB_STICKY_OVF_EN is defined.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef ALU_ARB_STICKY_OVF_EN
  input  logic                     sticky_clr,
  output logic                     sticky_ovf,
`endif
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*8-1:0]     req_a,
  input  logic [NUM_REQ*8-1:0]     req_b,
  input  logic [NUM_REQ*4-1:0]     req_opcode,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic [3:0]               alu_opcode,
  input  logic [7:0]               alu_result,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  input  logic                     alu_overflow,
  input  logic                     alu_negative,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [7:0]               rsp_result,
  output logic [3:0]               rsp_flags,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     busy
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_gnt;
  logic [7:0]       r_a, r_b;
  logic [3:0]       r_op;
  logic [TAG_W-1:0] r_tag;
  logic [7:0]       r_result;
  alu_flags_t       r_flags;

  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_idx;
  logic               w_any;
  logic               w_accept;
  logic               w_done;
  logic [7:0]         w_a_arr   [NUM_REQ];
  logic [7:0]         w_b_arr   [NUM_REQ];
  logic [3:0]         w_op_arr  [NUM_REQ];
  logic [TAG_W-1:0]   w_tag_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_a_arr[i]   = req_a[i*8 +: 8];
      w_b_arr[i]   = req_b[i*8 +: 8];
      w_op_arr[i]  = req_opcode[i*4 +: 4];
      w_tag_arr[i] = req_tag[i*TAG_W +: TAG_W];
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and the source holds valid and
  // payload stable until that edge.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          req_ready   = w_grant;
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid[r_gnt] = 1'b1;
        if (rsp_ready[r_gnt]) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_tag    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a   <= w_a_arr[w_idx];
        r_b   <= w_b_arr[w_idx];
        r_op  <= w_op_arr[w_idx];
        r_tag <= w_tag_arr[w_idx];
        r_gnt <= w_idx;
      end
      if (r_state == ST_EXEC) begin
        r_result <= alu_result;
        r_flags  <= alu_flags_t'{c: alu_carry, z: alu_zero, v: alu_overflow, n: alu_negative};
      end
      // Fairness pointer moves past the served port only once its response retires.
      if (w_done) r_ptr <= (r_gnt == IW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
    end
  end

`ifdef ALU_ARB_STICKY_OVF_EN
  logic r_sticky;

  always_ff @(posedge clk) begin
    if (rst)                       r_sticky <= 1'b0;
    else if (w_done && r_flags.v)  r_sticky <= 1'b1;
    else if (sticky_clr)           r_sticky <= 1'b0;
  end

  assign sticky_ovf = r_sticky;
`endif

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_opcode = r_op;
  assign rsp_result = r_result;
  assign rsp_flags  = r_flags;
  assign rsp_tag    = r_tag;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stub, transaction-level round-robin
// model with an expected-response queue, directed cases then random traffic.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ*8-1:0]     req_a, req_b;
  logic [NUM_REQ*4-1:0]     req_opcode;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [7:0]               alu_a, alu_b, alu_result, rsp_result;
  logic [3:0]               alu_opcode, rsp_flags;
  logic                     alu_carry, alu_zero, alu_overflow, alu_negative;
  logic [TAG_W-1:0]         rsp_tag;
  logic                     busy;
`ifdef ALU_ARB_STICKY_OVF_EN
  logic sticky_clr, sticky_ovf;
  bit   m_sticky   = 1'b0;
  bit   clr_quiet  = 1'b0;
`endif

  alu_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef ALU_ARB_STICKY_OVF_EN
    .sticky_clr   (sticky_clr),
    .sticky_ovf   (sticky_ovf),
`endif
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_opcode   (req_opcode),
    .req_tag      (req_tag),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_negative (alu_negative),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .rsp_tag      (rsp_tag),
    .busy         (busy)
  );

  // Returns {result[7:0], C, Z, V, N}; C on SUB is the borrow.
  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    s = 9'd0; c = 1'b0; v = 1'b0;
    case (op)
      ALU_ADD: begin s = {1'b0, a} + {1'b0, b}; c = s[8]; v = (a[7] == b[7]) && (s[7] != a[7]); end
      ALU_SUB: begin s = {1'b0, a} - {1'b0, b}; c = s[8]; v = (a[7] != b[7]) && (s[7] != a[7]); end
      ALU_AND: s = {1'b0, a & b};
      ALU_OR:  s = {1'b0, a | b};
      default: s = 9'd0;
    endcase
    r = s[7:0];
    return {r, c, (r == 8'd0), v, r[7]};
  endfunction

  always_comb {alu_result, alu_carry, alu_zero, alu_overflow, alu_negative} =
    alu_model(alu_a, alu_b, alu_opcode);

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- requester model ----------------
  bit         pend [NUM_REQ];
  logic [7:0] pa   [NUM_REQ];
  logic [7:0] pb   [NUM_REQ];
  logic [3:0] pop  [NUM_REQ];
  logic [TAG_W-1:0] ptag [NUM_REQ];
  int m_ptr = 0;

  task automatic apply();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]                = pend[i];
      req_a[i*8 +: 8]             = pa[i];
      req_b[i*8 +: 8]             = pb[i];
      req_opcode[i*4 +: 4]        = pop[i];
      req_tag[i*TAG_W +: TAG_W]   = ptag[i];
    end
  endtask

  task automatic set_req(input int p, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic [TAG_W-1:0] tag);
    pend[p] = 1'b1; pa[p] = a; pb[p] = b; pop[p] = op; ptag[p] = tag;
  endtask

  task automatic refill();
    for (int i = 0; i < NUM_REQ; i++)
      if (!pend[i] && $urandom_range(0, 2) != 0)
        set_req(i, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 3)), TAG_W'($urandom));
  endtask

  function automatic int model_winner();
    for (int off = 0; off < NUM_REQ; off++)
      if (pend[(m_ptr + off) % NUM_REQ]) return (m_ptr + off) % NUM_REQ;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input bit done_now, input bit v_now);
    @(posedge clk);
`ifdef ALU_ARB_STICKY_OVF_EN
    if (rst)                     m_sticky = 1'b0;
    else if (done_now && v_now)  m_sticky = 1'b1;
    else if (sticky_clr)         m_sticky = 1'b0;
`endif
    @(negedge clk);
`ifdef ALU_ARB_STICKY_OVF_EN
    chk("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
    sticky_clr = clr_quiet ? 1'b0 : ($urandom_range(0, 5) == 0);
`endif
  endtask

  task automatic run_op(input int hold, input bit clr_done, output int g);
    logic [15:0] e;
    logic [7:0]  ea, eb;
    logic [3:0]  eop;
    apply();
    #1;
    g = model_winner();
    chk("busy_idle", 32'(busy), 32'd0);
    if (g < 0) begin
      chk("req_ready_none", 32'(req_ready), 32'd0);
      step(1'b0, 1'b0);
      return;
    end
    chk("req_ready_grant", 32'(req_ready), 32'(1 << g));
    exp_q.push_back({alu_model(pa[g], pb[g], pop[g]), ptag[g]});
    ea = pa[g]; eb = pb[g]; eop = pop[g];
    step(1'b0, 1'b0);
    pend[g] = 1'b0;
    refill();
    apply();
    rsp_ready = NUM_REQ'($urandom);
    rsp_ready[g] = 1'b0;
    #1;
    chk("busy_exec", 32'(busy), 32'd1);
    chk("req_ready_exec", 32'(req_ready), 32'd0);
    chk("rsp_valid_exec", 32'(rsp_valid), 32'd0);
    chk("alu_a", 32'(alu_a), 32'(ea));
    chk("alu_b", 32'(alu_b), 32'(eb));
    chk("alu_opcode", 32'(alu_opcode), 32'(eop));
    step(1'b0, 1'b0);
    rsp_ready = NUM_REQ'($urandom);
    rsp_ready[g] = (hold == 0);
    #1;
    e = exp_q.pop_front();
    chk("rsp_valid", 32'(rsp_valid), 32'(1 << g));
    chk("rsp_result", 32'(rsp_result), 32'(e[15:8]));
    chk("rsp_flags", 32'(rsp_flags), 32'(e[7:4]));
    chk("rsp_tag", 32'(rsp_tag), 32'(e[3:0]));
    chk("req_ready_resp", 32'(req_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      step(1'b0, 1'b0);
      refill();
      apply();
      rsp_ready = NUM_REQ'($urandom);
      rsp_ready[g] = (k == hold - 1);
      #1;
      chk("rsp_valid_hold", 32'(rsp_valid), 32'(1 << g));
      chk("rsp_result_hold", 32'(rsp_result), 32'(e[15:8]));
      chk("rsp_flags_hold", 32'(rsp_flags), 32'(e[7:4]));
      chk("req_ready_hold", 32'(req_ready), 32'd0);
    end
`ifdef ALU_ARB_STICKY_OVF_EN
    if (clr_done) sticky_clr = 1'b1;
`else
    if (clr_done) chk("clr_done_unused", 32'(busy), 32'd1);
`endif
    step(1'b1, e[5]);
    m_ptr = (g + 1) % NUM_REQ;
    rsp_ready = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g;
    rst = 1'b1;
    rsp_ready = '0;
`ifdef ALU_ARB_STICKY_OVF_EN
    sticky_clr = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; pop[i] = '0; ptag[i] = '0;
    end
    apply();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    rst = 1'b0;

    // 7F + 01 on port 0: result 80, C0 Z0 V1 N1, tag 3
    set_req(0, 8'h7F, 8'h01, ALU_ADD, 4'd3);
    run_op(0, 1'b0, g);
    chk("tp_add_port", 32'(g), 32'd0);
    chk("tp_add_model", 32'(alu_model(8'h7F, 8'h01, ALU_ADD)), 32'h803);

`ifdef ALU_ARB_STICKY_OVF_EN
    clr_quiet = 1'b1;
    set_req(1, 8'h0F, 8'hF0, ALU_AND, 4'd5);
    run_op(0, 1'b0, g);
    chk("sticky_held", 32'(sticky_ovf), 32'd1);
    sticky_clr = 1'b1;
    step(1'b0, 1'b0);
    chk("sticky_cleared", 32'(sticky_ovf), 32'd0);
    set_req(0, 8'h7F, 8'h01, ALU_ADD, 4'd6);
    run_op(1, 1'b1, g);
    chk("sticky_set_wins", 32'(sticky_ovf), 32'd1);
    clr_quiet = 1'b0;
`endif

    // 05 - 05 on port 1 with response held off for 10 cycles
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    set_req(1, 8'h05, 8'h05, ALU_SUB, 4'd9);
    run_op(10, 1'b0, g);
    chk("tp_sub_port", 32'(g), 32'd1);
    chk("tp_sub_model", 32'(alu_model(8'h05, 8'h05, ALU_SUB)), 32'h004);

    // All ports kept valid: grants rotate
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < NUM_REQ; p++)
        if (!pend[p]) set_req(p, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 3)), TAG_W'(p));
      run_op($urandom_range(0, 2), 1'b0, g);
      chk("rotate", 32'(g), 32'(i % NUM_REQ));
    end

    // Reset during EXEC discards the operation
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    set_req(1, 8'hAA, 8'h55, ALU_OR, 4'd7);
    apply();
    #1;
    chk("rst_exec_grant", 32'(req_ready), 32'(1 << ((m_ptr == 1 || !pend[0]) ? 1 : 0)));
    step(1'b0, 1'b0);
    pend[1] = 1'b0;
    apply();
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    m_ptr = 0;
    #1;
    chk("rexec_busy", 32'(busy), 32'd0);
    chk("rexec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rexec_rsp_result", 32'(rsp_result), 32'd0);
    chk("rexec_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rexec_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rexec_alu_a", 32'(alu_a), 32'd0);
    chk("rexec_alu_b", 32'(alu_b), 32'd0);
    chk("rexec_alu_opcode", 32'(alu_opcode), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0);
      #1;
      chk("rexec_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Simultaneous valids right after reset: port 0 first
    for (int p = 0; p < NUM_REQ; p++) set_req(p, 8'($urandom), 8'($urandom), ALU_SUB, TAG_W'(p + 1));
    run_op(0, 1'b0, g);
    chk("post_rst_winner", 32'(g), 32'd0);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      refill();
      run_op($urandom_range(0, 3), 1'b0, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational 8-bit `alu` between `NUM_REQ` requesters using a round-robin arbiter and a three-state sequencer. Requests (operands, opcode, tag) arrive on per-port valid/ready channels. Results and flags return on per-port response channels with backpressure. The block sits between the client blocks and the `alu` instance, which is instantiated beside it, not inside it.

## Interface
- `NUM_REQ`, 2: number of requester ports, 2..8.
- `TAG_W`, 4: width of the request tag echoed in the response.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-port request valid.
- `req_ready` out NUM_REQ: per-port request accept.
- `req_a`, `req_b` in NUM_REQ*8: packed operands; port i occupies [8i+7:8i].
- `req_opcode` in NUM_REQ*4: packed opcodes.
- `req_tag` in NUM_REQ*TAG_W: packed tags.
- `alu_a`, `alu_b` out 8: operands to the ALU.
- `alu_opcode` out 4: opcode to the ALU.
- `alu_result` in 8: result from the ALU.
- `alu_carry`, `alu_zero`, `alu_overflow`, `alu_negative` in 1 each: flags from the ALU.
- `rsp_valid` out NUM_REQ: per-port response valid.
- `rsp_ready` in NUM_REQ: per-port response accept.
- `rsp_result` out 8: shared response result; meaningful only for the port with `rsp_valid` high.
- `rsp_flags` out 4: {C,Z,V,N}.
- `rsp_tag` out TAG_W: echoed tag.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is high, the arbiter selects port g.
  - `req_ready[g]` = 1 combinationally in this cycle; all other `req_ready` bits = 0.
  - On the edge: latch a, b, opcode, tag and g into the operand registers, then go to EXEC.
- EXEC:
  - Operand registers drive `alu_a`, `alu_b`, `alu_opcode` (these drive the held operands in every state; they are 0 after reset).
  - On the edge: capture `alu_result` and the four flags into the response registers, then go to RESP.
- RESP:
  - `rsp_valid[g]` = 1 until `rsp_ready[g]`.
  - When `rsp_valid[g] & rsp_ready[g]`: go to IDLE and set the round-robin pointer to (g+1) mod NUM_REQ.
- Round-robin rule: the winner is the first valid port found scanning upward from the pointer, with wrap-around.
- `req_ready` is low in EXEC and RESP. Requesters hold valid and payload stable until accepted; withdrawing a request before it is accepted is a protocol violation.
- Ports not granted simply wait; there is no starvation bound beyond NUM_REQ grants.
- `rsp_ready` on non-granted ports is ignored.
- The pointer advances only on response completion, never on grant.

## Timing
- Request accepted at cycle T. `rsp_valid` rises at T+2.
- Minimum issue interval is 3 cycles per operation, with immediate `rsp_ready`.
- With `rsp_ready` held low, the response registers stay stable indefinitely.
- A new request presented in the cycle a response completes is granted no earlier than the next cycle, when the FSM is in IDLE.
- Reset values:
  - State IDLE, pointer 0.
  - `req_ready`, `rsp_valid`, `busy` all 0.
  - `rsp_result`, `rsp_flags`, `rsp_tag` all 0.
  - `alu_a`, `alu_b`, `alu_opcode` all 0.
- Reset asserted mid-operation discards the operation; no response is ever issued for it.
- Simultaneous valids out of reset: port 0 wins.

## Configuration
- `ALU_ARB_STICKY_OVF_EN` defined:
  - Adds input `sticky_clr` (1) and output `sticky_ovf` (1).
  - `sticky_ovf` sets on the RESP-completion edge when the captured V flag is 1.
  - It clears on `sticky_clr`; set wins if both happen in the same cycle.
  - Reset value 0.
- Not defined: both ports and the register are absent; all other behaviour is identical.

## Structure
- `alu_pkg` holds:
  - opcode constants (`ALU_ADD`=4'h0, `ALU_SUB`=4'h1, `ALU_AND`=4'h2, `ALU_OR`=4'h3).
  - the flags struct {C,Z,V,N}.
  - the FSM state enum.
- Sub-module `rr_arbiter`, parameterised by N:
  - Inputs: request vector, pointer.
  - Output: one-hot grant plus an encoded index.
  - Purely combinational.

## Test plan
- Port 0 sends A=8'h7F, B=8'h01, ADD, tag 3 with `rsp_ready` held high: accepted at T, `rsp_valid[0]` at T+2 with result 8'h80, flags C0 Z0 V1 N1, tag 3.
- Both ports valid out of reset: port 0 served first, then port 1. With both kept valid, grants alternate 0,1,0,1 over 4 operations.
- Port 1 sends SUB 8'h05-8'h05 with `rsp_ready[1]` low for 10 cycles: result 8'h00, Z=1, held stable. `req_ready` stays 0 on all ports throughout; completion follows on the cycle `rsp_ready` rises.
- Assert `rst` in EXEC: next cycle state is IDLE and all outputs are at reset values; no `rsp_valid` pulse occurs.
- With `ALU_ARB_STICKY_OVF_EN`: an overflowing ADD sets `sticky_ovf`, which stays 1 through a following non-overflow op. `sticky_clr` clears it; `sticky_clr` coinciding with an overflow completion leaves it at 1.
